// File: rtl/filter_reduce_accumulator.sv
// Per-chain bin classifier: pass-through, histogram, in-range flags or frame-accumulated histogram.
// Latency 2 cycles, 1 vector/cycle, no backpressure; byte-serial config bus with shadow/commit.
module filter_reduce_accumulator #(
    parameter int N                  = 8,
    parameter int M                  = 4,
    parameter int DATA_WIDTH         = 32,
    parameter int ACC_WIDTH          = 16,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    localparam int CHW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      tracing,
    input  logic                      valid_in,
    input  logic                      bof_in,
    input  logic                      eof_in,
    input  logic [CHW-1:0]            chainId_in,
    input  logic [N*DATA_WIDTH-1:0]   vector_in,
    input  logic [7:0]                configId,
    input  logic [7:0]                configData,
    output logic [N*DATA_WIDTH-1:0]   vector_out,
    output logic                      valid_out,
    output logic                      bof_out,
    output logic                      eof_out,
    output logic [CHW-1:0]            chainId_out
);

    localparam int NB   = M * DATA_WIDTH / 8;
    localparam int BCW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNTW = $clog2(N + 1);
    localparam int SW   = ACC_WIDTH + CNTW;
    localparam int THW  = M * DATA_WIDTH;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};

    typedef enum logic [1:0] {CFG_IDLE, CFG_HDR, CFG_DATA, CFG_COMMIT} cfg_state_t;

    cfg_state_t         cfg_state_q;
    logic [CHW-1:0]     cfg_chain_q;
    logic [1:0]         cfg_mode_q;
    logic [BCW-1:0]     cfg_cnt_q;
    logic [THW-1:0]     shadow_q;
    logic [1:0]         mode_q [MAX_CHAINS];
    // Thresholds kept in byte-arrival order: th[0] occupies the top DATA_WIDTH bits.
    logic [THW-1:0]     th_q   [MAX_CHAINS];

    logic cfg_hit;
    logic commit;
    assign cfg_hit = (configId == 8'(PERSONAL_CONFIG_ID));
    assign commit  = (cfg_state_q == CFG_COMMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_state_q <= CFG_IDLE;
            cfg_chain_q <= '0;
            cfg_mode_q  <= '0;
            cfg_cnt_q   <= '0;
            shadow_q    <= '0;
            for (int c = 0; c < MAX_CHAINS; c++) begin
                mode_q[c] <= '0;
                th_q[c]   <= '0;
            end
        end else begin
            case (cfg_state_q)
                CFG_IDLE: begin
                    if (cfg_hit) begin
                        cfg_chain_q <= configData[CHW-1:0];
                        cfg_state_q <= CFG_HDR;
                    end
                end
                CFG_HDR: begin
                    if (!cfg_hit) begin
                        cfg_state_q <= CFG_IDLE;
                    end else begin
                        cfg_mode_q  <= configData[1:0];
                        cfg_cnt_q   <= '0;
                        cfg_state_q <= CFG_DATA;
                    end
                end
                CFG_DATA: begin
                    if (!cfg_hit) begin
                        cfg_state_q <= CFG_IDLE;
                    end else begin
                        shadow_q <= (shadow_q << 8) | THW'(configData);
                        if (cfg_cnt_q == BCW'(NB - 1)) begin
                            cfg_state_q <= CFG_COMMIT;
                        end else begin
                            cfg_cnt_q <= cfg_cnt_q + 1'b1;
                        end
                    end
                end
                CFG_COMMIT: begin
                    for (int c = 0; c < MAX_CHAINS; c++) begin
                        if (cfg_chain_q == CHW'(c)) begin
                            mode_q[c] <= cfg_mode_q;
                            th_q[c]   <= shadow_q;
                        end
                    end
                    cfg_state_q <= CFG_IDLE;
                end
                default: cfg_state_q <= CFG_IDLE;
            endcase
        end
    end

    // Stage 1: capture vector, sideband and the addressed chain's live config.
    logic [1:0]   sel_mode;
    logic [THW-1:0] sel_th;
    always_comb begin
        sel_mode = '0;
        sel_th   = '0;
        for (int c = 0; c < MAX_CHAINS; c++) begin
            if (chainId_in == CHW'(c)) begin
                sel_mode = mode_q[c];
                sel_th   = th_q[c];
            end
        end
    end

    logic                    s1_vld_q;
    logic                    s1_bof_q;
    logic                    s1_eof_q;
    logic [CHW-1:0]          s1_chain_q;
    logic [N*DATA_WIDTH-1:0] s1_vec_q;
    logic [1:0]              s1_mode_q;
    logic [THW-1:0]          s1_th_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q   <= 1'b0;
            s1_bof_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            s1_chain_q <= '0;
            s1_vec_q   <= '0;
            s1_mode_q  <= '0;
            s1_th_q    <= '0;
        end else begin
            s1_vld_q <= valid_in & tracing;
            if (valid_in & tracing) begin
                s1_bof_q   <= bof_in;
                s1_eof_q   <= eof_in;
                s1_chain_q <= chainId_in;
                s1_vec_q   <= vector_in;
                s1_mode_q  <= sel_mode;
                s1_th_q    <= sel_th;
            end
        end
    end

    // Stage 2: classify, reduce per bin, update accumulator.
    logic [M:0]            gt     [N];
    logic [M-1:0]          in_bin [N];
    logic [N-1:0]          in_any;
    logic [CNTW-1:0]       cnt    [M];
    logic [ACC_WIDTH-1:0]  acc_q  [MAX_CHAINS][M];
    logic [ACC_WIDTH-1:0]  acc_sel[M];
    logic [ACC_WIDTH-1:0]  acc_new[M];
    logic [SW-1:0]         acc_sum[M];
    logic [N*DATA_WIDTH-1:0] res;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            gt[i][M] = 1'b0;
            for (int j = 0; j < M; j++) begin
                gt[i][j] = s1_vec_q[i*DATA_WIDTH +: DATA_WIDTH] >
                           s1_th_q[(M-1-j)*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int j = 0; j < M; j++) begin
                in_bin[i][j] = gt[i][j] & ~gt[i][j+1];
            end
            in_any[i] = |in_bin[i];
        end
        for (int j = 0; j < M; j++) begin
            cnt[j] = '0;
            for (int i = 0; i < N; i++) begin
                cnt[j] = cnt[j] + CNTW'(in_bin[i][j]);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < M; j++) begin
            acc_sel[j] = '0;
            for (int c = 0; c < MAX_CHAINS; c++) begin
                if (s1_chain_q == CHW'(c)) begin
                    acc_sel[j] = acc_q[c][j];
                end
            end
            acc_sum[j] = SW'(s1_bof_q ? '0 : acc_sel[j]) + SW'(cnt[j]);
            acc_new[j] = (acc_sum[j] > SW'(ACC_MAX)) ? ACC_MAX : acc_sum[j][ACC_WIDTH-1:0];
        end
    end

    always_comb begin
        res = '0;
        case (s1_mode_q)
            2'd0: res = s1_vec_q;
            2'd1: for (int j = 0; j < M; j++) res[j*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(cnt[j]);
            2'd2: for (int i = 0; i < N; i++) res[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(in_any[i]);
            default: for (int j = 0; j < M; j++) res[j*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(acc_new[j]);
        endcase
    end

    logic s2_fire;
    logic s2_frame;
    assign s2_fire  = s1_vld_q & tracing;
    assign s2_frame = s2_fire & (s1_mode_q == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < MAX_CHAINS; c++) begin
                for (int j = 0; j < M; j++) acc_q[c][j] <= '0;
            end
        end else begin
            for (int c = 0; c < MAX_CHAINS; c++) begin
                if (s2_frame && s1_chain_q == CHW'(c)) begin
                    for (int j = 0; j < M; j++) acc_q[c][j] <= s1_eof_q ? '0 : acc_new[j];
                end
                // A config commit always restarts the chain's frame, even over a same-cycle add.
                if (commit && cfg_chain_q == CHW'(c)) begin
                    for (int j = 0; j < M; j++) acc_q[c][j] <= '0;
                end
            end
        end
    end

    logic                    valid_out_q;
    logic                    bof_out_q;
    logic                    eof_out_q;
    logic [CHW-1:0]          chain_out_q;
    logic [N*DATA_WIDTH-1:0] vector_out_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_out_q  <= 1'b0;
            bof_out_q    <= 1'b0;
            eof_out_q    <= 1'b0;
            chain_out_q  <= '0;
            vector_out_q <= '0;
        end else begin
            valid_out_q <= s2_fire & ((s1_mode_q != 2'd3) | s1_eof_q);
            if (s2_fire) begin
                bof_out_q    <= s1_bof_q;
                eof_out_q    <= s1_eof_q;
                chain_out_q  <= s1_chain_q;
                vector_out_q <= res;
            end
        end
    end

    assign vector_out  = vector_out_q;
    assign valid_out   = valid_out_q;
    assign bof_out     = bof_out_q;
    assign eof_out     = eof_out_q;
    assign chainId_out = chain_out_q;

endmodule
